// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder:
//   - state_e    : control FSM states (IDLE, RUN)
//   - cnt_width  : width of the bit counter for an N-bit operation
// No ports; imported by serial_adder and its bit cell.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Bit counter width. The counter indexes bits 0..N-1, so $clog2(N) bits
   // suffice. N=1 would give zero bits, so the width is floored at 1.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// half_adder / full_adder
// Combinational bit cells for the serial adder.
//
// half_adder ports:
//   a, b  in  : addend bits
//   s     out : a ^ b
//   c     out : a & b
//
// full_adder ports:
//   a, b  in  : addend bits
//   ci    in  : carry in
//   s     out : sum bit
//   co    out : carry out
// The full adder is built from two half adders; the two partial carries can
// never both be 1, so a plain OR merges them.
// -----------------------------------------------------------------------------
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule : half_adder

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic s1;
   logic c1;
   logic c2;

   half_adder u_ha_ab (
      .a (a),
      .b (b),
      .s (s1),
      .c (c1)
   );

   half_adder u_ha_ci (
      .a (s1),
      .b (ci),
      .s (s),
      .c (c2)
   );

   assign co = c1 | c2;

endmodule : full_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial N-bit adder. Operands and carry-in are captured on the accepting
// edge, then one sum bit per clock is produced by a single full-adder cell,
// LSB first. After N bit-cycles the result is published with a one-cycle
// done pulse.
//
// Parameters:
//   N         operand / sum width (N >= 1)
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   request a new addition (only honoured while not busy)
//   a, b      in   N-bit operands, sampled on the accepting edge
//   cin       in   carry-in, sampled on the accepting edge
//   busy      out  operation in progress
//   done      out  one-cycle pulse, results newly valid
//   sum       out  N-bit result, held until the next completion
//   cout      out  unsigned carry out of bit N-1
//   overflow  out  two's-complement overflow (carry into MSB ^ carry out)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         overflow
);

   localparam int CW = cnt_width(N);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_e          state_q, state_d;
   logic [N-1:0]    opa_q,   opa_d;     // operand A, shifts right each bit
   logic [N-1:0]    opb_q,   opb_d;     // operand B, shifts right each bit
   logic [N-1:0]    res_q,   res_d;     // result, sum bits enter at the MSB
   logic            carry_q, carry_d;   // carry into the current bit
   logic [CW-1:0]   cnt_q,   cnt_d;     // index of the bit being processed
   logic [N-1:0]    sum_q,   sum_d;
   logic            cout_q,  cout_d;
   logic            ovf_q,   ovf_d;
   logic            done_q,  done_d;

   // ---------------------------------------------------------------------
   // Bit cell
   // ---------------------------------------------------------------------
   logic fa_s;
   logic fa_co;

   full_adder u_fa (
      .a  (opa_q[0]),
      .b  (opb_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // Result register after this cycle's sum bit is shifted in. Built with a
   // shift plus a bit overwrite rather than a concatenation so that N=1 needs
   // no zero-width slice.
   logic [N-1:0] res_shift;
   logic         last_bit;

   always_comb begin
      res_shift        = res_q >> 1;
      res_shift[N-1]   = fa_s;
   end

   assign last_bit = (cnt_q == CW'(N - 1));

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   // NOTE: every signal driven here is given its hold value first, so no
   // path through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               opa_d   = a;
               opb_d   = b;
               res_d   = '0;
               carry_d = cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            opa_d   = opa_q >> 1;
            opb_d   = opb_q >> 1;
            res_d   = res_shift;
            carry_d = fa_co;
            cnt_d   = cnt_q + CW'(1);

            if (last_bit) begin
               // carry_q is still the carry into the MSB at this point, so
               // comparing it with the MSB carry-out gives signed overflow.
               sum_d   = res_shift;
               cout_d  = fa_co;
               ovf_d   = fa_co ^ carry_q;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values computed above, independent of order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign busy     = (state_q == RUN);
   assign done     = done_q;
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Directed bench for serial_adder: an N=8 instance for the main sequence and
// an N=1 instance for the single-bit corner. Inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_serial_adder;

   logic       clk;
   logic       rst_n;

   // N=8 instance
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;
   logic       overflow;

   // N=1 instance
   logic       start1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       cin1;
   logic       busy1;
   logic       done1;
   logic [0:0] sum1;
   logic       cout1;
   logic       overflow1;

   int total = 0;
   int bad   = 0;

   serial_adder #(.N(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow)
   );

   serial_adder #(.N(1)) dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start1),
      .a        (a1),
      .b        (b1),
      .cin      (cin1),
      .busy     (busy1),
      .done     (done1),
      .sum      (sum1),
      .cout     (cout1),
      .overflow (overflow1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (on falling edges) until done rises; returns the number of edges
   // waited. Gives up after a fixed budget and records a failure.
   task automatic wait_done(input string tag, output int cycles);
      cycles = 0;
      while (done !== 1'b1 && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
      if (done !== 1'b1) check({tag, "_timeout"}, 32'(done), 32'd1);
   endtask

   // One isolated operation on the N=8 instance, checking latency and results.
   task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                         input logic tc, input logic [7:0] es, input logic ec,
                         input logic eo);
      int cyc;
      start = 1'b1;
      a     = ta;
      b     = tb;
      cin   = tc;
      @(negedge clk);                     // accepting edge has passed
      check({tag, "_busy"}, 32'(busy), 32'd1);
      start = 1'b0;
      a     = 8'hEE;                      // must not be resampled
      b     = 8'hEE;
      cin   = 1'b1;
      wait_done(tag, cyc);
      check({tag, "_lat"},  32'(cyc),      32'd8);
      check({tag, "_sum"},  32'(sum),      32'(es));
      check({tag, "_cout"}, 32'(cout),     32'(ec));
      check({tag, "_ovf"},  32'(overflow), 32'(eo));
      check({tag, "_idle"}, 32'(busy),     32'd0);
      @(negedge clk);
      check({tag, "_pulse"}, 32'(done),    32'd0);
      check({tag, "_hold"},  32'(sum),     32'(es));
   endtask

   initial begin
      int cyc;
      int dones;
      logic [7:0] va [5];
      logic [7:0] vb [5];
      logic       vc [5];
      logic [7:0] vs [5];
      logic       vco[5];
      logic       vo [5];

      rst_n  = 1'b0;
      start  = 1'b0;
      a      = '0;
      b      = '0;
      cin    = 1'b0;
      start1 = 1'b0;
      a1     = '0;
      b1     = '0;
      cin1   = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_busy", 32'(busy),     32'd0);
      check("rst_done", 32'(done),     32'd0);
      check("rst_sum",  32'(sum),      32'd0);
      check("rst_cout", 32'(cout),     32'd0);
      check("rst_ovf",  32'(overflow), 32'd0);
      check("rst_busy1", 32'(busy1),   32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic additions, including carry-out and signed overflow corners
      run_op("op_5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
      run_op("op_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op("op_7f_00", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
      run_op("op_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

      // start while busy is ignored
      start = 1'b1;
      a     = 8'h01;
      b     = 8'h02;
      cin   = 1'b0;
      @(negedge clk);                     // accepted
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;                       // mid-operation pulse
      a     = 8'h11;
      @(negedge clk);
      start = 1'b0;
      wait_done("ign", cyc);
      check("ign_sum", 32'(sum), 32'h03);
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      check("ign_no_second_done", 32'(dones), 32'd0);
      check("ign_busy", 32'(busy), 32'd0);

      // Reset in the middle of an operation
      start = 1'b1;
      a     = 8'h44;
      b     = 8'h22;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_sum",  32'(sum),  32'd0);
      rst_n = 1'b1;
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      check("mid_rst_no_done", 32'(dones), 32'd0);
      check("mid_rst_sum_held", 32'(sum), 32'd0);
      run_op("post_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

      // Back-to-back with start held high; operands for the next operation
      // are presented right after each accept.
      va[0] = 8'h12; vb[0] = 8'h34; vc[0] = 1'b0; vs[0] = 8'h46; vco[0] = 1'b0; vo[0] = 1'b0;
      va[1] = 8'hC8; vb[1] = 8'h64; vc[1] = 1'b0; vs[1] = 8'h2C; vco[1] = 1'b1; vo[1] = 1'b0;
      va[2] = 8'h40; vb[2] = 8'h40; vc[2] = 1'b0; vs[2] = 8'h80; vco[2] = 1'b0; vo[2] = 1'b1;
      va[3] = 8'h0F; vb[3] = 8'hF0; vc[3] = 1'b1; vs[3] = 8'h00; vco[3] = 1'b1; vo[3] = 1'b0;
      va[4] = 8'h00; vb[4] = 8'h00; vc[4] = 1'b0; vs[4] = 8'h00; vco[4] = 1'b0; vo[4] = 1'b0;
      start = 1'b1;
      a     = va[0];
      b     = vb[0];
      cin   = vc[0];
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);                  // accept of operation k
         a   = va[k+1];
         b   = vb[k+1];
         cin = vc[k+1];
         if (k == 3) start = 1'b0;
         wait_done("b2b", cyc);
         check($sformatf("b2b%0d_period", k), 32'(cyc + ((k == 0) ? 0 : 1)),
               (k == 0) ? 32'd8 : 32'd9);
         check($sformatf("b2b%0d_sum",  k), 32'(sum),      32'(vs[k]));
         check($sformatf("b2b%0d_cout", k), 32'(cout),     32'(vco[k]));
         check($sformatf("b2b%0d_ovf",  k), 32'(overflow), 32'(vo[k]));
      end
      @(negedge clk);
      check("b2b_end_busy", 32'(busy), 32'd0);

      // N=1: 1 + 1 + 1 = 3
      start1 = 1'b1;
      a1     = 1'b1;
      b1     = 1'b1;
      cin1   = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("n1_busy", 32'(busy1), 32'd1);
      @(negedge clk);
      check("n1_done", 32'(done1),     32'd1);
      check("n1_sum",  32'(sum1),      32'd1);
      check("n1_cout", 32'(cout1),     32'd1);
      check("n1_ovf",  32'(overflow1), 32'd0);
      @(negedge clk);
      check("n1_pulse", 32'(done1), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_serial_adder
